// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, exact fill level, threshold flags
// and sticky error flags; FWFT selects combinational head or registered read.
module sync_fifo #(
    parameter int FIFO_DATW  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int FIFO_CNTW  = 5,
    parameter int FWFT       = 0
) (
    input  logic                 clk,
    input  logic                 rst_async_n,
    input  logic                 rst_sync,
    input  logic                 we,
    input  logic [FIFO_DATW-1:0] din,
    input  logic                 re,
    input  logic [FIFO_CNTW:0]   aempty_val,
    input  logic [FIFO_CNTW:0]   afull_val,
    input  logic                 clr_err,
    output logic [FIFO_DATW-1:0] dout,
    output logic                 rvalid,
    output logic                 empty,
    output logic                 full,
    output logic                 aempty,
    output logic                 afull,
    output logic [FIFO_CNTW:0]   level,
    output logic                 overf,
    output logic                 underf
);

    localparam logic [FIFO_CNTW:0] DEPTH_L = (FIFO_CNTW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_CNTW:0] PTR_ONE = (FIFO_CNTW+1)'(1);

    logic [FIFO_DATW-1:0] mem [0:FIFO_DEPTH-1];

    logic [FIFO_CNTW:0] wbin_reg;
    logic [FIFO_CNTW:0] rbin_reg;
    logic               overf_reg;
    logic               underf_reg;
    logic               wena;
    logic               rena;
    logic [FIFO_CNTW-1:0] waddr;
    logic [FIFO_CNTW-1:0] raddr;

    // The wrap bit makes the modular difference exact, 0..FIFO_DEPTH.
    assign level  = wbin_reg - rbin_reg;
    assign empty  = (level == '0);
    assign full   = (level == DEPTH_L);
    assign aempty = (level <= aempty_val);
    assign afull  = (level >= afull_val);
    assign overf  = overf_reg;
    assign underf = underf_reg;

    assign wena  = we & ~full;
    assign rena  = re & ~empty;
    assign waddr = wbin_reg[FIFO_CNTW-1:0];
    assign raddr = rbin_reg[FIFO_CNTW-1:0];

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            wbin_reg   <= '0;
            rbin_reg   <= '0;
            overf_reg  <= 1'b0;
            underf_reg <= 1'b0;
        end else if (rst_sync) begin
            wbin_reg   <= '0;
            rbin_reg   <= '0;
            overf_reg  <= 1'b0;
            underf_reg <= 1'b0;
        end else begin
            if (wena) wbin_reg <= wbin_reg + PTR_ONE;
            if (rena) rbin_reg <= rbin_reg + PTR_ONE;
            // A new error in the same cycle as clr_err keeps the flag set.
            overf_reg  <= (we & full)  | (overf_reg  & ~clr_err);
            underf_reg <= (re & empty) | (underf_reg & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wena) mem[waddr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout   = mem[raddr];
            assign rvalid = ~empty;
        end else begin : g_reg_read
            logic [FIFO_DATW-1:0] dout_reg;
            logic                 rvalid_reg;

            always_ff @(posedge clk or negedge rst_async_n) begin
                if (!rst_async_n) begin
                    dout_reg   <= '0;
                    rvalid_reg <= 1'b0;
                end else if (rst_sync) begin
                    dout_reg   <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rena;
                    if (rena) dout_reg <= mem[raddr];
                end
            end

            assign dout   = dout_reg;
            assign rvalid = rvalid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: one registered-read and one FWFT FIFO share the stimulus and
// are compared every cycle against a queue model, plus hand-computed spot checks.
module tb_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 32;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_async_n = 1'b0;
    logic          rst_sync = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  din = '0;
    logic [CW:0]   aempty_val = 6'd4;
    logic [CW:0]   afull_val = 6'd28;

    logic [W-1:0]  dout0, dout1;
    logic          rvalid0, rvalid1;
    logic          empty0, full0, aempty0, afull0, overf0, underf0;
    logic          empty1, full1, aempty1, afull1, overf1, underf1;
    logic [CW:0]   level0, level1;

    sync_fifo #(.FIFO_DATW(W), .FIFO_DEPTH(D), .FIFO_CNTW(CW), .FWFT(0)) u0 (
        .clk(clk), .rst_async_n(rst_async_n), .rst_sync(rst_sync),
        .we(we), .din(din), .re(re),
        .aempty_val(aempty_val), .afull_val(afull_val), .clr_err(clr_err),
        .dout(dout0), .rvalid(rvalid0), .empty(empty0), .full(full0),
        .aempty(aempty0), .afull(afull0), .level(level0),
        .overf(overf0), .underf(underf0)
    );

    sync_fifo #(.FIFO_DATW(W), .FIFO_DEPTH(D), .FIFO_CNTW(CW), .FWFT(1)) u1 (
        .clk(clk), .rst_async_n(rst_async_n), .rst_sync(rst_sync),
        .we(we), .din(din), .re(re),
        .aempty_val(aempty_val), .afull_val(afull_val), .clr_err(clr_err),
        .dout(dout1), .rvalid(rvalid1), .empty(empty1), .full(full1),
        .aempty(aempty1), .afull(afull1), .level(level1),
        .overf(overf1), .underf(underf1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus error flags and the last read word.
    logic [W-1:0] q[$];
    bit           m_ov, m_un, m_rv0;
    logic [W-1:0] m_dout0;

    always @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n || rst_sync) begin
            q.delete();
            m_ov    = 1'b0;
            m_un    = 1'b0;
            m_rv0   = 1'b0;
            m_dout0 = '0;
        end else begin
            bit was_full, was_empty;
            was_full  = (q.size() == D);
            was_empty = (q.size() == 0);
            m_rv0 = re && !was_empty;
            if (re && !was_empty) m_dout0 = q.pop_front();
            if (we && !was_full) q.push_back(din);
            m_ov = (we && was_full)  || (m_ov && !clr_err);
            m_un = (re && was_empty) || (m_un && !clr_err);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int lv;
            lv = q.size();
            chk("level0", level0, lv);
            chk("level1", level1, lv);
            chk("empty0", empty0, lv == 0);
            chk("empty1", empty1, lv == 0);
            chk("full0", full0, lv == D);
            chk("full1", full1, lv == D);
            chk("aempty0", aempty0, lv <= int'(aempty_val));
            chk("aempty1", aempty1, lv <= int'(aempty_val));
            chk("afull0", afull0, lv >= int'(afull_val));
            chk("afull1", afull1, lv >= int'(afull_val));
            chk("overf0", overf0, m_ov);
            chk("overf1", overf1, m_ov);
            chk("underf0", underf0, m_un);
            chk("underf1", underf1, m_un);
            chk("rvalid0", rvalid0, m_rv0);
            chk("dout0", dout0, m_dout0);
            chk("rvalid1", rvalid1, lv != 0);
            if (lv != 0) chk("dout1", dout1, q[0]);
        end
    end

    // Inputs change just after the falling edge; after a call the state reflects
    // the previous call's inputs.
    task automatic cyc(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        @(negedge clk);
        #1;
        we = w; din = d; re = r; clr_err = c;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_async_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_level", level0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_aempty", aempty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_afull", afull0, 0);
        chk("rst_overf", overf0, 0);
        chk("rst_underf", underf0, 0);
        chk("rst_dout0", dout0, 0);

        // Fill with 0x00..0x1F then one rejected write
        for (int i = 0; i < 32; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        idle();
        chk("fill_level", level0, 32);
        chk("fill_full", full0, 1);
        chk("fill_afull", afull0, 1);
        chk("fill_overf", overf0, 1);

        // Drain with re held, one extra read
        for (int i = 0; i < 33; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("drain_empty", empty0, 1);
        chk("drain_underf", underf0, 1);
        chk("drain_last", dout0, 8'h1F);
        chk("drain_rvalid", rvalid0, 0);

        cyc(1'b0, '0, 1'b0, 1'b1);
        idle();
        chk("clr_overf", overf0, 0);
        chk("clr_underf", underf0, 0);

        // FWFT head visibility
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        idle();
        chk("fwft_empty", empty1, 0);
        chk("fwft_dout", dout1, 8'hA5);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("fwft_pop_empty", empty1, 1);
        chk("reg_dout", dout0, 8'hA5);
        chk("reg_rvalid", rvalid0, 1);

        // Level 10 then 100 cycles of simultaneous we & re
        for (int i = 0; i < 10; i++) cyc(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cyc(1'b1, W'(8'h80 + i), 1'b1, 1'b0);
        idle();
        chk("stream_level", level0, 10);

        // we & re at full
        for (int i = 0; i < 22; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        idle();
        chk("wr_full_level", level0, 31);
        chk("wr_full_overf", overf0, 1);
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        cyc(1'b1, 8'h79, 1'b0, 1'b1);
        idle();
        chk("clr_vs_set_overf", overf0, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle();
        chk("clr2_overf", overf0, 0);

        // we & re at empty
        for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1, 1'b0);
        idle();
        chk("wr_empty_level", level0, 1);
        chk("wr_empty_underf", underf0, 1);
        cyc(1'b0, '0, 1'b1, 1'b1);

        // Synchronous flush at level 17, overriding concurrent requests
        for (int i = 0; i < 17; i++) cyc(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
        idle();
        chk("pre_flush_level", level0, 17);
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        rst_sync = 1'b1;
        idle();
        rst_sync = 1'b0;
        chk("flush_level", level0, 0);
        chk("flush_empty", empty0, 1);

        // Threshold changes act combinationally
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
        idle();
        aempty_val = 6'd4; afull_val = 6'd0;
        #1;
        chk("thr_aempty_off", aempty0, 0);
        chk("thr_afull_zero", afull0, 1);
        aempty_val = 6'd32; afull_val = 6'd6;
        #1;
        chk("thr_aempty_max", aempty0, 1);
        chk("thr_afull_off", afull0, 0);
        idle();
        aempty_val = 6'd4; afull_val = 6'd28;

        // Async reset in the middle of a burst
        for (int i = 0; i < 8; i++) cyc(1'b1, W'(8'hD0 + i), i > 3, 1'b0);
        #2 rst_async_n = 1'b0;
        #1;
        chk("arst_level", level0, 0);
        chk("arst_empty", empty0, 1);
        chk("arst_rvalid", rvalid0, 0);
        chk("arst_dout0", dout0, 0);
        idle();
        idle();
        rst_async_n = 1'b1;
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        idle();
        chk("post_arst_dout0", dout0, 8'hC3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
